// File: rtl/cacode_search_seq.sv
// rtl/cacode_search_seq.sv - serial C/A-code acquisition search sequencer
// Optional PRN mask: define CACODE_SEARCH_MASK_EN to add the prn_mask port.
module cacode_search_seq #(
  parameter int DWELL_W  = 16,
  parameter int LFSR_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [5:0]         prn_first,
  input  logic [5:0]         prn_last,
  input  logic [DWELL_W-1:0] dwell_len,
`ifdef CACODE_SEARCH_MASK_EN
  input  logic [31:0]        prn_mask,
`endif
  output logic [9:0]         phase,
  output logic [3:0]         t0,
  output logic [3:0]         t1,
  output logic               gen_rst,
  output logic               corr_clr,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [5:0]         cur_prn,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LOAD, S_DWELL, S_DUMP, S_DONE
  } state_t;

  localparam logic [DWELL_W-1:0] LAT_LAST = DWELL_W'(LFSR_LAT - 1);

  state_t               state_q, state_d;
  logic [DWELL_W-1:0]   cnt_q;
  logic [DWELL_W-1:0]   dwell_q;
  logic [5:0]           last_q;
  logic [31:0]          mask_q;
  logic [31:0]          mask_in;
  logic [9:0]           phase_q;
  logic [5:0]           prn_q;
  logic                 cfg_err_q;
  logic [5:0]           first_prn;
  logic [5:0]           nxt_prn;
  logic                 cfg_ok;
  logic                 last_phase;

`ifdef CACODE_SEARCH_MASK_EN
  assign mask_in = prn_mask;
`else
  assign mask_in = '1;
`endif

  // Lowest enabled PRN in [from, last]; 0 when there is none.
  function automatic logic [5:0] find_prn(input logic [5:0] from, input logic [5:0] last,
                                          input logic [31:0] mask);
    logic [5:0]  r;
    logic [63:0] m;
    r = 6'd0;
    m = {31'd0, mask, 1'b0};
    for (int i = 32; i >= 1; i--) begin
      if (6'(i) >= from && 6'(i) <= last && m[6'(i)]) r = 6'(i);
    end
    return r;
  endfunction

  // G2 phase-selector tap pair {t0, t1} for each PRN.
  function automatic logic [7:0] g2_taps(input logic [5:0] prn);
    case (prn)
      6'd1:  g2_taps = {4'd2, 4'd6};   6'd2:  g2_taps = {4'd3, 4'd7};
      6'd3:  g2_taps = {4'd4, 4'd8};   6'd4:  g2_taps = {4'd5, 4'd9};
      6'd5:  g2_taps = {4'd1, 4'd9};   6'd6:  g2_taps = {4'd2, 4'd10};
      6'd7:  g2_taps = {4'd1, 4'd8};   6'd8:  g2_taps = {4'd2, 4'd9};
      6'd9:  g2_taps = {4'd3, 4'd10};  6'd10: g2_taps = {4'd2, 4'd3};
      6'd11: g2_taps = {4'd3, 4'd4};   6'd12: g2_taps = {4'd5, 4'd6};
      6'd13: g2_taps = {4'd6, 4'd7};   6'd14: g2_taps = {4'd7, 4'd8};
      6'd15: g2_taps = {4'd8, 4'd9};   6'd16: g2_taps = {4'd9, 4'd10};
      6'd17: g2_taps = {4'd1, 4'd4};   6'd18: g2_taps = {4'd2, 4'd5};
      6'd19: g2_taps = {4'd3, 4'd6};   6'd20: g2_taps = {4'd4, 4'd7};
      6'd21: g2_taps = {4'd5, 4'd8};   6'd22: g2_taps = {4'd6, 4'd9};
      6'd23: g2_taps = {4'd1, 4'd3};   6'd24: g2_taps = {4'd4, 4'd6};
      6'd25: g2_taps = {4'd5, 4'd7};   6'd26: g2_taps = {4'd6, 4'd8};
      6'd27: g2_taps = {4'd7, 4'd9};   6'd28: g2_taps = {4'd8, 4'd10};
      6'd29: g2_taps = {4'd1, 4'd6};   6'd30: g2_taps = {4'd2, 4'd7};
      6'd31: g2_taps = {4'd3, 4'd8};   6'd32: g2_taps = {4'd4, 4'd9};
      default: g2_taps = 8'd0;
    endcase
  endfunction

  assign first_prn  = find_prn(prn_first, prn_last, mask_in);
  assign nxt_prn    = find_prn(prn_q + 6'd1, last_q, mask_q);
  assign cfg_ok     = (prn_first != 6'd0) && (prn_last <= 6'd32) &&
                      (prn_first <= prn_last) && (first_prn != 6'd0);
  assign last_phase = (phase_q == 10'd1022);

  assign phase      = phase_q;
  assign cur_prn    = prn_q;
  assign {t0, t1}   = g2_taps(prn_q);
  assign cfg_err    = cfg_err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and per-state outputs; abort overrides every transition.
  always_comb begin
    state_d    = state_q;
    gen_rst    = 1'b0;
    corr_clr   = 1'b0;
    dump_valid = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start && cfg_ok) state_d = S_SETUP;
      end
      S_SETUP: if (cnt_q == LAT_LAST) state_d = S_LOAD;
      S_LOAD:  state_d = S_DWELL;
      S_DWELL: begin
        gen_rst  = 1'b1;
        corr_clr = (cnt_q == '0);
        if (cnt_q == dwell_q - 1'b1) state_d = S_DUMP;
      end
      S_DUMP: begin
        gen_rst    = 1'b1;
        dump_valid = 1'b1;
        if (dump_ready) state_d = (last_phase && nxt_prn == 6'd0) ? S_DONE : S_SETUP;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // Search configuration, hypothesis registers and the shared setup/dwell counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      dwell_q   <= DWELL_W'(1);
      last_q    <= 6'd0;
      mask_q    <= '0;
      phase_q   <= 10'd0;
      prn_q     <= 6'd0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            if (cfg_ok) begin
              last_q  <= prn_last;
              dwell_q <= (dwell_len == '0) ? DWELL_W'(1) : dwell_len;
              mask_q  <= mask_in;
              phase_q <= 10'd0;
              prn_q   <= first_prn;
              cnt_q   <= '0;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        S_SETUP: cnt_q <= (cnt_q == LAT_LAST) ? '0 : cnt_q + 1'b1;
        S_LOAD:  cnt_q <= '0;
        S_DWELL: cnt_q <= cnt_q + 1'b1;
        S_DUMP: begin
          if (dump_ready && !abort) begin
            cnt_q <= '0;
            if (last_phase) begin
              phase_q <= 10'd0;
              if (nxt_prn != 6'd0) prn_q <= nxt_prn;
            end else begin
              phase_q <= phase_q + 10'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
